stopwatch_core: RTL and testbench
=================================

STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter: DIV, default 50_000_000, clk cycles per counted second (legal range 2 .. 2^32-1).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start_stop  input  1  run/pause request from debounced button; acts on each 0->1 transition only.
REQ-005 clear  input  1  return-to-zero request; level, sampled every cycle.
REQ-006 sec_ones  output  4  BCD seconds units, range 0-9.
REQ-007 sec_tens  output  4  BCD seconds tens, range 0-5.
REQ-008 min_ones  output  4  BCD minutes units, range 0-9.
REQ-009 min_tens  output  4  BCD minutes tens, range 0-5.
REQ-010 running  output  1  high exactly while state is RUN.
REQ-011 wrap  output  1  one-cycle pulse when count rolls 59:59 -> 00:00.

Function
REQ-012 FSM states SHALL be IDLE, RUN, PAUSE; running SHALL be registered and high only in RUN.
REQ-013 A start_stop edge (start_stop=1 and previous-cycle start_stop=0) SHALL move IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-014 Holding start_stop high SHALL produce exactly one transition.
REQ-015 clear=1 SHALL force IDLE from any state, zero all digits and the prescaler on that edge, and override a simultaneous start_stop edge.
REQ-016 In IDLE, digits and prescaler SHALL be held at zero.
REQ-017 In RUN, the prescaler SHALL increment every cycle from 0 to DIV-1, then wrap to 0 while generating an internal one-cycle sec_tick.
REQ-018 In PAUSE, the prescaler and digits SHALL hold, so that resuming preserves the partial second.
REQ-019 Latency: if RUN is entered at edge k, sec_ones SHALL become 1 at edge k+DIV, and every DIV edges thereafter while in RUN.
REQ-020 Cascade: sec_ones 9->0 carries into sec_tens; sec_tens 5->0 carries into min_ones; min_ones 9->0 carries into min_tens; min_tens 5->0 completes the wrap.
REQ-021 All four digits SHALL update on the same edge; no intermediate illegal value SHALL ever be visible.
REQ-022 At 59:59 plus sec_tick, digits SHALL become 00:00, wrap SHALL be high for that one cycle, and the state SHALL remain RUN.
REQ-023 A start_stop edge coinciding with sec_tick in RUN SHALL apply the increment and enter PAUSE on the same edge.
REQ-024 Digit outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-025 reset=1 SHALL, on the next rising edge, set state to IDLE, all digits to 0, running=0, wrap=0, prescaler=0, and the start_stop history register to 0.
REQ-026 reset SHALL override clear and start_stop, including when asserted mid-count or mid-wrap.
REQ-027 A start_stop already high when reset deasserts SHALL NOT be treated as an edge until it has gone low and high again.

Structure
REQ-028 Package stopwatch_pkg SHALL hold typedef enum state_t {IDLE, RUN, PAUSE} and constants ONES_MAX=9 and TENS_MAX=5.
REQ-029 Sub-module bcd_digit SHALL be a mod-N BCD counter (parameter MAX; inputs clk, reset, clr, en; outputs q[3:0], carry=en&&(q==MAX)), instantiated four times and chained by carry.
REQ-030 The prescaler width SHALL be $clog2(DIV).

Verification (bench uses DIV=4)
REQ-031 Reset, then start_stop pulse at edge 0 -> sec_ones=1 at edge 4, 2 at edge 8; running=1 from edge 0.
REQ-032 Run to 00:03 plus 2 cycles, pulse start_stop, wait 20 cycles, pulse start_stop -> digits hold at 00:03 while paused, then 00:04 exactly 2 cycles after resume.
REQ-033 Run through 00:09 -> 00:10 and 00:59 -> 01:00 -> all carries land on a single edge and no digit is ever out of range.
REQ-034 Run from 59:58 -> 59:59 then 00:00 with wrap=1 for exactly one cycle and running still 1.
REQ-035 Hold start_stop high 10 cycles from IDLE -> a single transition to RUN; clear and start_stop edge on the same cycle -> IDLE, 00:00.
REQ-036 Assert reset mid-count at 12:34 while start_stop is held high -> 00:00, running=0 on the next edge; no RUN entry until a fresh start_stop edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the MM:SS stopwatch core.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// Single mod-(MAX+1) BCD digit; carry asserts on the enable that rolls it over.
module bcd_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (en) begin
      q_d = (q_q == MAX) ? 4'd0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = en && (q_q == MAX);

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch: IDLE/RUN/PAUSE control, seconds prescaler and four
// chained BCD digits that all update on the same clock edge.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       wrap,
  output state_t     state_dbg
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          ss_q;
  logic          armed_q, armed_d;
  logic          running_q, running_d;
  logic          wrap_q, wrap_d;

  logic          ss_edge;
  logic          sec_tick;
  logic          digit_clr;
  logic          c_so, c_st, c_mo, c_mt;

  // A button still held from before reset must be released once before
  // its next rising edge can count.
  assign ss_edge  = start_stop && !ss_q && armed_q;
  assign sec_tick = (state_q == RUN) && (presc_q == PRESC_MAX);
  assign armed_d  = armed_q || !start_stop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      ss_q      <= 1'b0;
      armed_q   <= 1'b0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      ss_q      <= start_stop;
      armed_q   <= armed_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (ss_edge) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    running_d = (state_d == RUN);
    digit_clr = clear || (state_q == IDLE);
    wrap_d    = c_mt && !clear;
    presc_d   = presc_q;
    if (digit_clr) begin
      presc_d = '0;
    end else if (state_q == RUN) begin
      presc_d = sec_tick ? '0 : presc_q + 1'b1;
    end
  end

  bcd_digit #(.MAX(ONES_MAX)) u_sec_ones (
    .clk(clk), .reset(reset), .clr(digit_clr), .en(sec_tick),
    .q(sec_ones), .carry(c_so)
  );

  bcd_digit #(.MAX(TENS_MAX)) u_sec_tens (
    .clk(clk), .reset(reset), .clr(digit_clr), .en(c_so),
    .q(sec_tens), .carry(c_st)
  );

  bcd_digit #(.MAX(ONES_MAX)) u_min_ones (
    .clk(clk), .reset(reset), .clr(digit_clr), .en(c_st),
    .q(min_ones), .carry(c_mo)
  );

  bcd_digit #(.MAX(TENS_MAX)) u_min_tens (
    .clk(clk), .reset(reset), .clr(digit_clr), .en(c_mo),
    .q(min_tens), .carry(c_mt)
  );

  assign running   = running_q;
  assign wrap      = wrap_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with DIV=4; digits are compared as a
// packed 16-bit BCD word MM:SS (e.g. 16'h1234 means 12:34).
module tb_stopwatch_core;
  import stopwatch_pkg::*;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running, wrap;
  state_t     state_dbg;
  logic [15:0] digits;

  int checks = 0;
  int errors = 0;
  int m_secs = 0;
  int m_presc = 0;
  logic m_wrap = 1'b0;

  stopwatch_core #(.DIV(DIV)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
    .min_tens(min_tens), .running(running), .wrap(wrap),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign digits = {min_tens, min_ones, sec_tens, sec_ones};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] to_bcd(int s);
    int m, sc;
    m  = s / 60;
    sc = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  // Free-running RUN with no input activity, tracked by a seconds model.
  task automatic run_cycles(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      tick();
      if (m_presc == DIV - 1) begin
        m_presc = 0;
        m_secs  = (m_secs + 1) % 3600;
        m_wrap  = (m_secs == 0);
      end else begin
        m_presc = m_presc + 1;
        m_wrap  = 1'b0;
      end
      checks++;
      if (digits !== to_bcd(m_secs) || wrap !== m_wrap || running !== 1'b1) begin
        errors++;
        $display("FAIL %s cycle %0d: digits=%h wrap=%b running=%b, expected digits=%h wrap=%b running=1",
                 name, i, digits, wrap, running, to_bcd(m_secs), m_wrap);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start_stop = 1'b0; clear = 1'b0;
    tick(); tick();
    checks++;
    if (digits !== 16'h0000 || running !== 1'b0 || wrap !== 1'b0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_state: digits=%h running=%b wrap=%b state=%0d, expected 0000/0/0/IDLE",
               digits, running, wrap, state_dbg);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (state_dbg !== IDLE || digits !== 16'h0000) begin
      errors++;
      $display("FAIL idle_after_reset: state=%0d digits=%h, expected IDLE 0000", state_dbg, digits);
    end
  endtask

  task automatic test_start();
    logic [15:0] exp;
    start_stop = 1'b1;
    tick();
    checks++;
    if (running !== 1'b1 || state_dbg !== RUN || digits !== 16'h0000) begin
      errors++;
      $display("FAIL start_edge0: running=%b state=%0d digits=%h, expected 1 RUN 0000",
               running, state_dbg, digits);
    end
    start_stop = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp = 16'(e / DIV);
      checks++;
      if (digits !== exp || running !== 1'b1) begin
        errors++;
        $display("FAIL start_latency edge %0d: digits=%h running=%b, expected %h running=1",
                 e, digits, running, exp);
      end
    end
    m_secs = 2; m_presc = 0;
  endtask

  task automatic test_pause_resume();
    run_cycles(DIV, "run_to_0003");
    tick();
    checks++;
    if (digits !== 16'h0003) begin
      errors++;
      $display("FAIL pre_pause: digits=%h, expected 0003", digits);
    end
    start_stop = 1'b1;
    tick();
    checks++;
    if (state_dbg !== PAUSE || running !== 1'b0 || digits !== 16'h0003) begin
      errors++;
      $display("FAIL pause_entry: state=%0d running=%b digits=%h, expected PAUSE 0 0003",
               state_dbg, running, digits);
    end
    start_stop = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (digits !== 16'h0003 || running !== 1'b0) begin
        errors++;
        $display("FAIL paused_hold cycle %0d: digits=%h running=%b, expected 0003 0", i, digits, running);
      end
    end
    start_stop = 1'b1;
    tick();
    checks++;
    if (state_dbg !== RUN || running !== 1'b1 || digits !== 16'h0003) begin
      errors++;
      $display("FAIL resume: state=%0d running=%b digits=%h, expected RUN 1 0003",
               state_dbg, running, digits);
    end
    start_stop = 1'b0;
    tick();
    checks++;
    if (digits !== 16'h0003) begin
      errors++;
      $display("FAIL resume_plus1: digits=%h, expected 0003", digits);
    end
    tick();
    checks++;
    if (digits !== 16'h0004) begin
      errors++;
      $display("FAIL resume_plus2: digits=%h, expected 0004", digits);
    end
    m_secs = 4; m_presc = 0;
  endtask

  task automatic test_carries();
    run_cycles(5 * DIV, "run_to_0009");
    for (int i = 0; i < DIV - 1; i++) begin
      tick();
      checks++;
      if (digits !== 16'h0009) begin
        errors++;
        $display("FAIL hold_0009 cycle %0d: digits=%h, expected 0009", i, digits);
      end
    end
    tick();
    checks++;
    if (digits !== 16'h0010) begin
      errors++;
      $display("FAIL carry_0010: digits=%h, expected 0010", digits);
    end
    m_secs = 10; m_presc = 0;
    run_cycles(49 * DIV, "run_to_0059");
    for (int i = 0; i < DIV - 1; i++) begin
      tick();
      checks++;
      if (digits !== 16'h0059) begin
        errors++;
        $display("FAIL hold_0059 cycle %0d: digits=%h, expected 0059", i, digits);
      end
    end
    tick();
    checks++;
    if (digits !== 16'h0100) begin
      errors++;
      $display("FAIL carry_0100: digits=%h, expected 0100", digits);
    end
    m_secs = 60; m_presc = 0;
  endtask

  task automatic test_wrap();
    run_cycles((3598 - 60) * DIV, "run_to_5958");
    checks++;
    if (digits !== 16'h5958) begin
      errors++;
      $display("FAIL at_5958: digits=%h, expected 5958", digits);
    end
    run_cycles(DIV, "run_to_5959");
    for (int i = 0; i < DIV - 1; i++) begin
      tick();
      checks++;
      if (digits !== 16'h5959 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL hold_5959 cycle %0d: digits=%h wrap=%b, expected 5959 0", i, digits, wrap);
      end
    end
    tick();
    checks++;
    if (digits !== 16'h0000 || wrap !== 1'b1 || running !== 1'b1 || state_dbg !== RUN) begin
      errors++;
      $display("FAIL wrap_edge: digits=%h wrap=%b running=%b state=%0d, expected 0000 1 1 RUN",
               digits, wrap, running, state_dbg);
    end
    tick();
    checks++;
    if (digits !== 16'h0000 || wrap !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL wrap_after: digits=%h wrap=%b running=%b, expected 0000 0 1", digits, wrap, running);
    end
  endtask

  task automatic test_hold_and_clear();
    clear = 1'b1;
    tick();
    checks++;
    if (state_dbg !== IDLE || running !== 1'b0 || digits !== 16'h0000) begin
      errors++;
      $display("FAIL clear_from_run: state=%0d running=%b digits=%h, expected IDLE 0 0000",
               state_dbg, running, digits);
    end
    clear = 1'b0;
    tick();
    start_stop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (state_dbg !== RUN || running !== 1'b1) begin
        errors++;
        $display("FAIL hold_single_transition cycle %0d: state=%0d running=%b, expected RUN 1",
                 i, state_dbg, running);
      end
    end
    start_stop = 1'b0;
    tick();
    start_stop = 1'b1; clear = 1'b1;
    tick();
    checks++;
    if (state_dbg !== IDLE || running !== 1'b0 || digits !== 16'h0000) begin
      errors++;
      $display("FAIL clear_over_edge: state=%0d running=%b digits=%h, expected IDLE 0 0000",
               state_dbg, running, digits);
    end
    start_stop = 1'b0; clear = 1'b0;
    tick();
    checks++;
    if (state_dbg !== IDLE || digits !== 16'h0000) begin
      errors++;
      $display("FAIL idle_hold: state=%0d digits=%h, expected IDLE 0000", state_dbg, digits);
    end
  endtask

  task automatic test_reset_mid_count();
    start_stop = 1'b1;
    tick();
    start_stop = 1'b0;
    m_secs = 0; m_presc = 0;
    run_cycles(754 * DIV, "run_to_1234");
    checks++;
    if (digits !== 16'h1234) begin
      errors++;
      $display("FAIL at_1234: digits=%h, expected 1234", digits);
    end
    start_stop = 1'b1; reset = 1'b1;
    tick();
    checks++;
    if (digits !== 16'h0000 || running !== 1'b0 || wrap !== 1'b0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_mid_count: digits=%h running=%b wrap=%b state=%0d, expected 0000 0 0 IDLE",
               digits, running, wrap, state_dbg);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (state_dbg !== IDLE || running !== 1'b0) begin
        errors++;
        $display("FAIL held_after_reset cycle %0d: state=%0d running=%b, expected IDLE 0",
                 i, state_dbg, running);
      end
    end
    start_stop = 1'b0;
    tick();
    start_stop = 1'b1;
    tick();
    checks++;
    if (state_dbg !== RUN || running !== 1'b1) begin
      errors++;
      $display("FAIL fresh_edge_run: state=%0d running=%b, expected RUN 1", state_dbg, running);
    end
  endtask

  task automatic test_tick_pause();
    start_stop = 1'b0;
    for (int i = 1; i < DIV; i++) begin
      tick();
      checks++;
      if (digits !== 16'h0000) begin
        errors++;
        $display("FAIL before_tick edge %0d: digits=%h, expected 0000", i, digits);
      end
    end
    start_stop = 1'b1;
    tick();
    checks++;
    if (digits !== 16'h0001 || state_dbg !== PAUSE || running !== 1'b0) begin
      errors++;
      $display("FAIL tick_and_pause: digits=%h state=%0d running=%b, expected 0001 PAUSE 0",
               digits, state_dbg, running);
    end
    start_stop = 1'b0;
    tick();
    checks++;
    if (digits !== 16'h0001 || state_dbg !== PAUSE) begin
      errors++;
      $display("FAIL paused_after_tick: digits=%h state=%0d, expected 0001 PAUSE", digits, state_dbg);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_pause_resume();
    test_carries();
    test_wrap();
    test_hold_and_clear();
    test_reset_mid_count();
    test_tick_pause();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
